// File: rtl/pic_host_sequencer_if.sv
// PIC-side bus between the host sequencer (master) and the 8259A core (slave).
interface pic_host_sequencer_if;
  logic       pic_chip_select_n;
  logic       pic_write_enable_n;
  logic       pic_read_enable_n;
  logic       pic_interrupt_acknowledge_n;
  logic       pic_address;
  logic [7:0] pic_data_out;
  logic       pic_interrupt_to_cpu;
  logic [7:0] pic_data_in;
  logic       pic_data_bus_io;

  modport master (
    output pic_chip_select_n, pic_write_enable_n, pic_read_enable_n,
           pic_interrupt_acknowledge_n, pic_address, pic_data_out,
    input  pic_interrupt_to_cpu, pic_data_in, pic_data_bus_io
  );

  modport slave (
    input  pic_chip_select_n, pic_write_enable_n, pic_read_enable_n,
           pic_interrupt_acknowledge_n, pic_address, pic_data_out,
    output pic_interrupt_to_cpu, pic_data_in, pic_data_bus_io
  );
endinterface

// File: rtl/pic_host_sequencer.sv
// Host-side sequencer for an 8259A: init writes, INTA train + vector capture,
// non-specific EOI, and runtime OCW1 mask updates on a shared PIC bus.
module pic_host_sequencer #(
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic [7:0] ocw1,
  input  logic       mask_update_valid,
  input  logic [7:0] mask_update_data,
  output logic       mask_update_ready,
  output logic [7:0] vector_out,
  output logic       vector_valid,
  input  logic       vector_ready,
  output logic       vector_spurious,
  output logic       init_done,
  output logic       busy,
  pic_host_sequencer_if.master pic
);

  localparam int PULSE = STROBE_CYCLES + GAP_CYCLES;
  localparam int CW    = $clog2(PULSE);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE - 1);
  localparam logic [7:0]    EOI_NS      = 8'h20;

  typedef enum logic [2:0] {
    UNINIT, INIT_WR, IDLE, INTA, VEC_WAIT, EOI_WR, MASK_WR
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    pulse;
  logic [2:0]    item;
  logic [7:0]    icw2_q, icw3_q, icw4_q, ocw1_q;
  logic          cascade, has_icw4, mode8086, auto_eoi;
  logic          cs_n, we_n, inta_n, addr;
  logic [7:0]    dout;

  logic [2:0]    nxt_item;
  logic [7:0]    nxt_data;
  logic          strobe_end, pulse_end, start_ok, last_item;
  logic [1:0]    last_pulse;

  assign strobe_end = (cnt == STROBE_LAST);
  assign pulse_end  = (cnt == PULSE_LAST);
  assign start_ok   = start && (state == UNINIT || state == IDLE);
  assign last_item  = (item == 3'd4);
  assign last_pulse = mode8086 ? 2'd1 : 2'd2;

  assign pic.pic_chip_select_n           = cs_n;
  assign pic.pic_write_enable_n          = we_n;
  assign pic.pic_read_enable_n           = 1'b1;
  assign pic.pic_interrupt_acknowledge_n = inta_n;
  assign pic.pic_address                 = addr;
  assign pic.pic_data_out                = dout;

  // Init list items: 0=ICW1 1=ICW2 2=ICW3 3=ICW4 4=OCW1; ICW3/ICW4 skipped per ICW1.
  always_comb begin
    nxt_item = 3'd4;
    nxt_data = ocw1_q;
    case (item)
      3'd0: begin
        nxt_item = 3'd1;
        nxt_data = icw2_q;
      end
      3'd1: begin
        if (cascade) begin
          nxt_item = 3'd2;
          nxt_data = icw3_q;
        end else if (has_icw4) begin
          nxt_item = 3'd3;
          nxt_data = icw4_q;
        end
      end
      3'd2: begin
        if (has_icw4) begin
          nxt_item = 3'd3;
          nxt_data = icw4_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= UNINIT;
      cnt               <= '0;
      pulse             <= '0;
      item              <= '0;
      icw2_q            <= '0;
      icw3_q            <= '0;
      icw4_q            <= '0;
      ocw1_q            <= '0;
      cascade           <= 1'b0;
      has_icw4          <= 1'b0;
      mode8086          <= 1'b0;
      auto_eoi          <= 1'b0;
      cs_n              <= 1'b1;
      we_n              <= 1'b1;
      inta_n            <= 1'b1;
      addr              <= 1'b0;
      dout              <= '0;
      vector_out        <= '0;
      vector_valid      <= 1'b0;
      vector_spurious   <= 1'b0;
      init_done         <= 1'b0;
      busy              <= 1'b0;
      mask_update_ready <= 1'b0;
    end else begin
      mask_update_ready <= 1'b0;
      if (start_ok) begin
        icw2_q       <= icw2;
        icw3_q       <= icw3;
        icw4_q       <= icw4;
        ocw1_q       <= ocw1;
        cascade      <= ~icw1[1];
        has_icw4     <= icw1[0];
        mode8086     <= icw1[0] & icw4[0];
        auto_eoi     <= icw1[0] & icw4[1];
        init_done    <= 1'b0;
        vector_valid <= 1'b0;
        busy         <= 1'b1;
        state        <= INIT_WR;
        item         <= 3'd0;
        cnt          <= '0;
        addr         <= 1'b0;
        dout         <= icw1 | 8'h10;
        cs_n         <= 1'b0;
        we_n         <= 1'b0;
      end else begin
        case (state)
          INIT_WR, EOI_WR, MASK_WR: begin
            cnt <= cnt + 1'b1;
            if (strobe_end) begin
              cs_n <= 1'b1;
              we_n <= 1'b1;
            end
            // Address/data stay put through the gap; only the next write changes them.
            if (pulse_end) begin
              cnt <= '0;
              if (state == INIT_WR && !last_item) begin
                item <= nxt_item;
                addr <= 1'b1;
                dout <= nxt_data;
                cs_n <= 1'b0;
                we_n <= 1'b0;
              end else begin
                if (state == INIT_WR) init_done <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          IDLE: begin
            if (pic.pic_interrupt_to_cpu) begin
              state  <= INTA;
              busy   <= 1'b1;
              cnt    <= '0;
              pulse  <= '0;
              inta_n <= 1'b0;
            end else if (mask_update_valid) begin
              mask_update_ready <= 1'b1;
              state             <= MASK_WR;
              busy              <= 1'b1;
              cnt               <= '0;
              addr              <= 1'b1;
              dout              <= mask_update_data;
              cs_n              <= 1'b0;
              we_n              <= 1'b0;
            end
          end
          INTA: begin
            cnt <= cnt + 1'b1;
            if (strobe_end) begin
              inta_n <= 1'b1;
              // The PIC presents the vector on the second pulse in both modes.
              if (pulse == 2'd1) begin
                vector_out      <= pic.pic_data_in;
                vector_spurious <= pic.pic_data_bus_io;
              end
            end
            if (pulse_end) begin
              cnt <= '0;
              if (pulse == last_pulse) begin
                state        <= VEC_WAIT;
                vector_valid <= 1'b1;
              end else begin
                pulse  <= pulse + 1'b1;
                inta_n <= 1'b0;
              end
            end
          end
          VEC_WAIT: begin
            if (vector_ready) begin
              vector_valid <= 1'b0;
              if (auto_eoi) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= EOI_WR;
                cnt   <= '0;
                addr  <= 1'b0;
                dout  <= EOI_NS;
                cs_n  <= 1'b0;
                we_n  <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Randomized bench for pic_host_sequencer: bus monitor + PIC responder, with
// expectations computed from the init/INTA/EOI rules and cycle arithmetic.
module tb_pic_host_sequencer;
  localparam int S = 2;
  localparam int G = 2;
  localparam int P = S + G;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] icw1 = '0, icw2 = '0, icw3 = '0, icw4 = '0, ocw1 = '0;
  logic       mask_update_valid = 1'b0;
  logic [7:0] mask_update_data = '0;
  logic       mask_update_ready;
  logic [7:0] vector_out;
  logic       vector_valid;
  logic       vector_ready = 1'b0;
  logic       vector_spurious;
  logic       init_done;
  logic       busy;

  pic_host_sequencer_if pic_bus();

  pic_host_sequencer #(.STROBE_CYCLES(S), .GAP_CYCLES(G)) dut (
    .clock(clock), .reset(reset), .start(start),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .ocw1(ocw1),
    .mask_update_valid(mask_update_valid), .mask_update_data(mask_update_data),
    .mask_update_ready(mask_update_ready),
    .vector_out(vector_out), .vector_valid(vector_valid),
    .vector_ready(vector_ready), .vector_spurious(vector_spurious),
    .init_done(init_done), .busy(busy), .pic(pic_bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic a; logic [7:0] d; int low; } wr_t;
  wr_t wr_q[$];
  wr_t exp_q[$];
  int  inta_q[$];

  int n_chk = 0, n_fail = 0;
  int bad_bus = 0, rdy_cnt = 0;
  logic       m8086 = 1'b0, aeoi = 1'b0;
  logic [7:0] vec = '0;
  logic       cur_io = 1'b1;
  logic       int_line = 1'b0;
  logic [7:0] d_in = 8'hEE;
  logic       io_in = 1'b1;

  assign pic_bus.pic_interrupt_to_cpu = int_line;
  assign pic_bus.pic_data_in          = d_in;
  assign pic_bus.pic_data_bus_io      = io_in;

  wire       cs_n   = pic_bus.pic_chip_select_n;
  wire       we_n   = pic_bus.pic_write_enable_n;
  wire       re_n   = pic_bus.pic_read_enable_n;
  wire       inta_n = pic_bus.pic_interrupt_acknowledge_n;
  wire       a0     = pic_bus.pic_address;
  wire [7:0] dout   = pic_bus.pic_data_out;

  function automatic wr_t mk(input logic a, input logic [7:0] d);
    wr_t w;
    w.a = a; w.d = d; w.low = S;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bus monitor and PIC responder: the PIC drives the vector only on the last
  // low cycle of the second INTA pulse, garbage otherwise.
  logic       cs_prev = 1'b1, inta_prev = 1'b1;
  logic       w_a = 1'b0;
  logic [7:0] w_d = '0;
  int         w_low = 0, gap_left = 0, pno = 0, lc = 0;

  always @(negedge clock) begin : mon
    int n_pno, n_lc;
    n_pno = pno;
    n_lc  = lc;
    if (mask_update_ready === 1'b1) rdy_cnt <= rdy_cnt + 1;
    if (we_n !== cs_n || re_n !== 1'b1 || (cs_n === 1'b0 && inta_n === 1'b0))
      bad_bus <= bad_bus + 1;
    if (cs_n === 1'b0) begin
      if (cs_prev) begin
        w_a <= a0; w_d <= dout; w_low <= 1;
      end else begin
        w_low <= w_low + 1;
        if (a0 !== w_a || dout !== w_d) bad_bus <= bad_bus + 1;
      end
    end else if (!cs_prev) begin
      wr_q.push_back('{w_a, w_d, w_low});
      gap_left <= G - 1;
      if (a0 !== w_a || dout !== w_d) bad_bus <= bad_bus + 1;
    end else if (gap_left > 0) begin
      gap_left <= gap_left - 1;
      if (a0 !== w_a || dout !== w_d) bad_bus <= bad_bus + 1;
    end
    cs_prev <= (cs_n === 1'b0) ? 1'b0 : 1'b1;

    if (inta_n === 1'b0) begin
      if (inta_prev) begin n_pno = pno + 1; n_lc = 1; end
      else n_lc = lc + 1;
    end else if (!inta_prev) begin
      inta_q.push_back(lc);
    end
    if (reset || vector_valid === 1'b1) n_pno = 0;
    pno       <= n_pno;
    lc        <= n_lc;
    inta_prev <= (inta_n === 1'b0) ? 1'b0 : 1'b1;
    if (inta_n === 1'b0 && n_pno == 2 && n_lc == S) begin
      d_in <= vec; io_in <= cur_io;
    end else begin
      d_in <= 8'hEE; io_in <= 1'b1;
    end
  end

  task automatic cmp_writes(input string tag, input int base);
    chk({tag, "_wr_count"}, wr_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < wr_q.size()) begin
        chk({tag, "_wr_a0"},   wr_q[base+i].a,   exp_q[i].a);
        chk({tag, "_wr_data"}, wr_q[base+i].d,   exp_q[i].d);
        chk({tag, "_wr_low"},  wr_q[base+i].low, exp_q[i].low);
      end
    end
  endtask

  task automatic run_init(input logic [7:0] i1, i2, i3, i4, o1);
    int t, base;
    exp_q.delete();
    exp_q.push_back(mk(1'b0, i1 | 8'h10));
    exp_q.push_back(mk(1'b1, i2));
    if (i1[1] == 1'b0) exp_q.push_back(mk(1'b1, i3));
    if (i1[0] == 1'b1) exp_q.push_back(mk(1'b1, i4));
    exp_q.push_back(mk(1'b1, o1));
    m8086 = i1[0] & i4[0];
    aeoi  = i1[0] & i4[1];
    base  = wr_q.size();
    icw1 = i1; icw2 = i2; icw3 = i3; icw4 = i4; ocw1 = o1;
    start = 1'b1;
    t = cyc;
    @(negedge clock);
    start = 1'b0;
    icw1 = 8'($urandom); icw2 = 8'($urandom); icw3 = 8'($urandom);
    icw4 = 8'($urandom); ocw1 = 8'($urandom);
    while (init_done !== 1'b1 && cyc < t + 100) @(negedge clock);
    chk("init_done_cycle", cyc, t + 1 + exp_q.size() * P);
    chk("init_busy", busy, 1'b0);
    cmp_writes("init", base);
  endtask

  task automatic service(input logic [7:0] v, input logic io, input int rdy_dly,
                         input logic with_mask, input logic [7:0] mdata, input logic poke);
    int t, np, wbase, ibase, r0, vc, e, drop;
    np    = m8086 ? 2 : 3;
    wbase = wr_q.size();
    ibase = inta_q.size();
    r0    = rdy_cnt;
    exp_q.delete();
    vec = v; cur_io = io; int_line = 1'b1;
    if (with_mask) begin mask_update_valid = 1'b1; mask_update_data = mdata; end
    t = cyc;
    @(negedge clock);
    chk("inta_first_low", inta_n, 1'b0);
    if (poke) begin
      start = 1'b1; icw1 = 8'($urandom);
      @(negedge clock);
      start = 1'b0;
    end
    drop = $urandom_range(0, 3);
    repeat (drop) @(negedge clock);
    int_line = 1'b0;
    while (vector_valid !== 1'b1 && cyc < t + 60) @(negedge clock);
    chk("vec_valid_cycle", cyc, t + 1 + np * P);
    chk("inta_pulses", inta_q.size() - ibase, np);
    for (int i = 0; i < np; i++)
      if (ibase + i < inta_q.size()) chk("inta_low", inta_q[ibase+i], S);
    chk("vector_out", vector_out, v);
    chk("vector_spurious", vector_spurious, io);
    repeat (rdy_dly) begin
      @(negedge clock);
      chk("vec_hold_valid", vector_valid, 1'b1);
      chk("vec_hold_data", {vector_spurious, vector_out}, {io, v});
    end
    vector_ready = 1'b1;
    vc = cyc;
    @(negedge clock);
    vector_ready = 1'b0;
    chk("valid_drop", vector_valid, 1'b0);
    chk("eoi_strobe", cs_n, aeoi);
    while (busy !== 1'b0 && cyc < vc + 40) @(negedge clock);
    chk("idle_cycle", cyc, vc + 1 + (aeoi ? 0 : P));
    if (!aeoi) exp_q.push_back(mk(1'b0, 8'h20));
    chk("no_ready_in_service", rdy_cnt - r0, 0);
    if (with_mask) begin
      e = cyc;
      while (mask_update_ready !== 1'b1 && cyc < e + 4) @(negedge clock);
      chk("mask_ready_cycle", cyc, e + 1);
      mask_update_valid = 1'b0;
      while (busy !== 1'b0 && cyc < e + 40) @(negedge clock);
      chk("mask_idle_cycle", cyc, e + 1 + P);
      exp_q.push_back(mk(1'b1, mdata));
    end
    cmp_writes("svc", wbase);
    chk("init_done_kept", init_done, 1'b1);
  endtask

  task automatic mask_only(input logic [7:0] mdata);
    int t, wbase;
    wbase = wr_q.size();
    exp_q.delete();
    exp_q.push_back(mk(1'b1, mdata));
    mask_update_valid = 1'b1; mask_update_data = mdata;
    t = cyc;
    @(negedge clock);
    chk("mask_ready", mask_update_ready, 1'b1);
    chk("mask_strobe", cs_n, 1'b0);
    mask_update_valid = 1'b0;
    mask_update_data  = 8'($urandom);
    @(negedge clock);
    chk("mask_ready_pulse", mask_update_ready, 1'b0);
    while (busy !== 1'b0 && cyc < t + 40) @(negedge clock);
    chk("mask_only_idle", cyc, t + 1 + P);
    cmp_writes("mask", wbase);
  endtask

  task automatic reset_mid_inta();
    vec = 8'($urandom); cur_io = 1'b0; int_line = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("inta_second_low", inta_n, 1'b0);
    reset = 1'b1; int_line = 1'b0;
    @(negedge clock);
    chk("rst_strobes", {cs_n, we_n, re_n, inta_n}, 4'hF);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", vector_valid, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("reset_strobes", {cs_n, we_n, re_n, inta_n}, 4'hF);
    chk("reset_addr_data", {a0, dout}, 9'h000);
    chk("reset_vector", vector_out, 8'h00);
    chk("reset_status", {vector_valid, vector_spurious, init_done, busy, mask_update_ready}, 5'b0);
    reset = 1'b0;
    int_line = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("uninit_no_inta", {inta_n, busy}, 2'b10);
    end
    int_line = 1'b0;
    @(negedge clock);

    run_init(8'h13, 8'h20, 8'hAA, 8'h01, 8'hFE);
    service(8'h21, 1'b0, 5, 1'b0, 8'h00, 1'b0);
    service(8'($urandom), 1'($urandom), $urandom_range(0, 4), 1'b0, 8'h00, 1'b0);

    run_init(8'h10, 8'($urandom), 8'h04, 8'h55, 8'hF0);
    service(8'h33, 1'b0, 2, 1'b0, 8'h00, 1'b0);

    run_init(8'h13, 8'h40, 8'h00, 8'h03, 8'h00);
    service(8'h47, 1'b0, 2, 1'b0, 8'h00, 1'b0);
    service(8'h47, 1'b1, 0, 1'b0, 8'h00, 1'b0);

    run_init(8'h13, 8'h20, 8'h00, 8'h01, 8'hFE);
    service(8'h21, 1'b0, 1, 1'b1, 8'h7F, 1'b0);
    mask_only(8'h3C);
    service(8'h2A, 1'b0, 0, 1'b0, 8'h00, 1'b1);

    reset_mid_inta();
    run_init(8'h11, 8'h08, 8'h02, 8'h01, 8'h00);
    service(8'h0B, 1'b0, 1, 1'b0, 8'h00, 1'b0);

    for (int it = 0; it < 12; it++) begin
      run_init(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 2) == 0) mask_only(8'($urandom));
        else service(8'($urandom), 1'($urandom), $urandom_range(0, 4),
                     1'($urandom), 8'($urandom), 1'($urandom));
      end
    end

    chk("bus_rules", bad_bus, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
